// File: rtl/pila_retorno.sv
// Return-address stack: LIFO of {intr_flag, z, addr} frames with zero-latency top read and sticky error FSM.
// Optional high-water-mark output when PILA_HWM_EN is defined.
module pila_retorno #(
    parameter int AW    = 10,
    parameter int DEPTH = 16,
    parameter int PW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          intr_entry,
    input  logic          s_return_intr,
    input  logic [AW-1:0] ret_addr_in,
    input  logic          z_in,
    input  logic          clr_err,
    output logic [AW-1:0] top_addr,
    output logic          z_restore,
    output logic          z_saved,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow,
    output logic [PW-1:0] sp,
`ifdef PILA_HWM_EN
    output logic [PW-1:0] hwm,
`endif
    output logic [1:0]    err_state
);

    localparam int IW = PW - 1;

    // Encoding chosen so bit 0 is the overflow flag and bit 1 the underflow flag.
    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_OVF  = 2'b01,
        ST_UNF  = 2'b10,
        ST_BOTH = 2'b11
    } err_state_e;

    logic [AW-1:0] addr_mem [DEPTH];
    logic          intr_mem [DEPTH];
    logic          z_mem    [DEPTH];

    logic [PW-1:0] sp_q, sp_next;
    err_state_e    state_q, state_next;

    logic          replace, push_eff, pop_eff, ovf_evt, unf_evt, wr_en;
    logic [IW-1:0] top_idx, wr_idx;
    logic          ovf_next, unf_next;

    assign empty   = (sp_q == '0);
    assign full    = (sp_q == PW'(DEPTH));
    assign top_idx = IW'(sp_q - PW'(1));

    // Push+pop on a non-empty stack rewrites the top frame; on an empty stack it is a plain push.
    assign replace  = push & pop & ~empty;
    assign push_eff = push & (~pop | empty) & ~full;
    assign pop_eff  = pop & ~push & ~empty;
    assign ovf_evt  = push & ~pop & full;
    assign unf_evt  = pop & ~push & empty;
    assign wr_en    = replace | push_eff;
    assign wr_idx   = replace ? top_idx : sp_q[IW-1:0];

    always_comb begin
        sp_next = sp_q;
        if (push_eff)
            sp_next = sp_q + PW'(1);
        else if (pop_eff)
            sp_next = sp_q - PW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            sp_q <= '0;
        else
            sp_q <= sp_next;
    end

    // Frame storage is never cleared; a low reset at the edge blocks the write.
    always_ff @(posedge clk) begin
        if (reset && wr_en) begin
            addr_mem[wr_idx] <= ret_addr_in;
            intr_mem[wr_idx] <= intr_entry;
            z_mem[wr_idx]    <= intr_entry & z_in;
        end
    end

    always_comb begin
        ovf_next   = ovf_evt | (state_q[0] & ~clr_err);
        unf_next   = unf_evt | (state_q[1] & ~clr_err);
        state_next = ST_OK;
        case ({unf_next, ovf_next})
            2'b01:   state_next = ST_OVF;
            2'b10:   state_next = ST_UNF;
            2'b11:   state_next = ST_BOTH;
            default: state_next = ST_OK;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_q <= ST_OK;
        else
            state_q <= state_next;
    end

    assign overflow  = (state_q == ST_OVF) || (state_q == ST_BOTH);
    assign underflow = (state_q == ST_UNF) || (state_q == ST_BOTH);
    assign err_state = state_q;
    assign sp        = sp_q;

    assign top_addr  = empty ? '0 : addr_mem[top_idx];
    assign z_saved   = empty ? 1'b0 : z_mem[top_idx];
    assign z_restore = pop & s_return_intr & ~empty & intr_mem[top_idx];

`ifdef PILA_HWM_EN
    logic [PW-1:0] hwm_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hwm_q <= '0;
        else if (clr_err)
            hwm_q <= sp_q;
        else if (sp_next > hwm_q)
            hwm_q <= sp_next;
    end

    assign hwm = hwm_q;
`endif

endmodule
